multicycle_control: RTL and testbench



---
 rtl/ctrl_pkg.sv | 75 +++++++
 rtl/ctrl_opclass_decode.sv | 34 +++
 rtl/multicycle_control.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multicycle control unit
//
// Purpose: opcode constants, FSM state enum, opcode class enum and the
// ALUOp / MemtoReg / pc_src / trap-cause encodings used by multicycle_control
// and ctrl_opclass_decode.
// Ports: none (package).
// Optional feature macro: MULTICYCLE_CONTROL_MULDIV_EN adds ST_MULDIV_WAIT.

package ctrl_pkg;

  // RV32I major opcodes handled by the sequencer
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_L     = 7'b0000011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // funct7 marking an M-extension op inside the R-type opcode space
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
`ifdef MULTICYCLE_CONTROL_MULDIV_EN
    ,
    ST_MULDIV_WAIT
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_S,
    CLS_L,
    CLS_B,
    CLS_JAL,
    CLS_JALR,
    CLS_AUIPC
  } opclass_e;

  // ALUOp classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // Writeback source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Next-PC select
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // Trap causes
  localparam logic [1:0] TRAP_NONE         = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL      = 2'd1;
  localparam logic [1:0] TRAP_IMEM_TIMEOUT = 2'd2;
  localparam logic [1:0] TRAP_DMEM_TIMEOUT = 2'd3;

  // Jumps write PC+4 back to rd
  function automatic logic is_link(input opclass_e c);
    return (c == CLS_JAL) || (c == CLS_JALR);
  endfunction

endpackage

// File: rtl/ctrl_opclass_decode.sv
// rtl/ctrl_opclass_decode.sv - combinational opcode to instruction class decoder
//
// Purpose: classify a 7-bit RV32I opcode into the control class used by the
// sequencer and flag anything outside the supported set.
// Ports:
//   opcode_i  [6:0]  opcode from the instruction register
//   opclass_o        decoded class (CLS_R when illegal)
//   illegal_o        1 when the opcode is not one of the supported classes

module ctrl_opclass_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output opclass_e   opclass_o,
  output logic       illegal_o
);

  always_comb begin
    opclass_o = CLS_R;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_R:     opclass_o = CLS_R;
      OPC_I:     opclass_o = CLS_I;
      OPC_S:     opclass_o = CLS_S;
      OPC_L:     opclass_o = CLS_L;
      OPC_B:     opclass_o = CLS_B;
      OPC_JAL:   opclass_o = CLS_JAL;
      OPC_JALR:  opclass_o = CLS_JALR;
      OPC_AUIPC: opclass_o = CLS_AUIPC;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle FSM main control unit for the RV32I core
//
// Purpose: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshakes with instruction/data memory, drives datapath enables, counts
// retired instructions and traps on illegal opcodes or hung memories.
// Optional feature macro: MULTICYCLE_CONTROL_MULDIV_EN (R-type funct7=0000001
// waits for the multiply/divide unit in an extra EXEC sub-state).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   opcode_i, funct7_i           instruction register fields
//   branch_taken_i               branch compare result (EXEC)
//   imem_ack_i, dmem_ack_i       memory handshakes
//   muldiv_done_i                multiply/divide completion
//   imem_req_o, ir_we_o          fetch request, IR load
//   dmem_req_o, MemRead_o, MemWrite_o  data memory access
//   RegWrite_o, MemtoReg_o       register writeback
//   ALUOp_o, ALUSrc_o, alu_a_sel_o     ALU controls
//   pc_we_o, pc_src_o            PC update
//   muldiv_start_o               multiply/divide start pulse
//   retire_o, retire_cnt_o       retire pulse and counter
//   trap_o, trap_cause_o         sticky trap flag and cause

module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W        = 2,
  parameter int MEMTOREG_W     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            opcode_i,
  input  logic [6:0]            funct7_i,
  input  logic                  branch_taken_i,
  input  logic                  imem_ack_i,
  input  logic                  dmem_ack_i,
  input  logic                  muldiv_done_i,
  output logic                  imem_req_o,
  output logic                  ir_we_o,
  output logic                  dmem_req_o,
  output logic                  MemRead_o,
  output logic                  MemWrite_o,
  output logic                  RegWrite_o,
  output logic [MEMTOREG_W-1:0] MemtoReg_o,
  output logic [ALUOP_W-1:0]    ALUOp_o,
  output logic                  ALUSrc_o,
  output logic                  alu_a_sel_o,
  output logic                  pc_we_o,
  output logic [1:0]            pc_src_o,
  output logic                  muldiv_start_o,
  output logic                  retire_o,
  output logic [CNT_W-1:0]      retire_cnt_o,
  output logic                  trap_o,
  output logic [1:0]            trap_cause_o
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The watchdog fires on the TIMEOUT_CYCLES-th ackless cycle in a state
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  opclass_e          cls_q, cls_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  opclass_e dec_cls;
  logic     dec_illegal;

`ifdef MULTICYCLE_CONTROL_MULDIV_EN
  logic muldiv_q, muldiv_d;
`else
  logic unused_muldiv;
  assign unused_muldiv = ^{funct7_i, muldiv_done_i};
`endif

  // Internal (ungated) datapath controls
  logic       imem_req_s, ir_we_s, dmem_req_s, mem_read_s, mem_write_s;
  logic       reg_write_s, alu_src_s, alu_a_sel_s, pc_we_s;
  logic       muldiv_start_s, retire_s;
  logic [1:0] memtoreg_s, aluop_s, pc_src_s;
  logic       run_s;

  ctrl_opclass_decode u_opclass_decode (
    .opcode_i  (opcode_i),
    .opclass_o (dec_cls),
    .illegal_o (dec_illegal)
  );

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cause_d      = cause_q;
    wait_d       = wait_q + WAIT_W'(1);
    retire_cnt_d = retire_cnt_q + CNT_W'(retire_s);
`ifdef MULTICYCLE_CONTROL_MULDIV_EN
    muldiv_d     = muldiv_q;
`endif

    case (state_q)
      ST_FETCH: begin
        // An ack on the limit cycle still wins over the watchdog
        if (imem_ack_i) begin
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
          cause_d = TRAP_IMEM_TIMEOUT;
        end
      end

      ST_DECODE: begin
        cls_d = dec_cls;
`ifdef MULTICYCLE_CONTROL_MULDIV_EN
        muldiv_d = (dec_cls == CLS_R) && !dec_illegal && (funct7_i == FUNCT7_MULDIV);
`endif
        if (dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls_q)
          CLS_B:        state_d = ST_FETCH;
          CLS_L, CLS_S: state_d = ST_MEM;
`ifdef MULTICYCLE_CONTROL_MULDIV_EN
          CLS_R:        state_d = muldiv_q ? ST_MULDIV_WAIT : ST_WB;
`endif
          default:      state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        if (dmem_ack_i) begin
          state_d = (cls_q == CLS_L) ? ST_WB : ST_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
          cause_d = TRAP_DMEM_TIMEOUT;
        end
      end

`ifdef MULTICYCLE_CONTROL_MULDIV_EN
      ST_MULDIV_WAIT: begin
        // A stuck multiply/divide unit is reported as a data-side hang
        if (muldiv_done_i) begin
          state_d = ST_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
          cause_d = TRAP_DMEM_TIMEOUT;
        end
      end
`endif

      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    // Every waiting state starts its watchdog from zero on entry
    if (state_d != state_q) begin
      wait_d = '0;
    end
  end

  // Single state register block
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_FETCH;
      cls_q        <= CLS_R;
      wait_q       <= '0;
      cause_q      <= TRAP_NONE;
      retire_cnt_q <= '0;
`ifdef MULTICYCLE_CONTROL_MULDIV_EN
      muldiv_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      wait_q       <= wait_d;
      cause_q      <= cause_d;
      retire_cnt_q <= retire_cnt_d;
`ifdef MULTICYCLE_CONTROL_MULDIV_EN
      muldiv_q     <= muldiv_d;
`endif
    end
  end

  // Output decode from state and latched class
  always_comb begin
    imem_req_s     = 1'b0;
    ir_we_s        = 1'b0;
    dmem_req_s     = 1'b0;
    mem_read_s     = 1'b0;
    mem_write_s    = 1'b0;
    reg_write_s    = 1'b0;
    memtoreg_s     = WB_ALU;
    aluop_s        = ALUOP_ADD;
    alu_src_s      = 1'b0;
    alu_a_sel_s    = 1'b0;
    pc_we_s        = 1'b0;
    pc_src_s       = PC_PLUS4;
    muldiv_start_s = 1'b0;
    retire_s       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        ir_we_s    = imem_ack_i;
      end

      ST_EXEC: begin
        case (cls_q)
          CLS_R: begin
            aluop_s = ALUOP_RTYPE;
`ifdef MULTICYCLE_CONTROL_MULDIV_EN
            muldiv_start_s = muldiv_q;
`endif
          end
          CLS_I: begin
            aluop_s   = ALUOP_ITYPE;
            alu_src_s = 1'b1;
          end
          CLS_AUIPC: begin
            alu_src_s   = 1'b1;
            alu_a_sel_s = 1'b1;
          end
          CLS_B: begin
            // Branches resolve and retire straight out of EXEC
            aluop_s  = ALUOP_SUB;
            pc_we_s  = 1'b1;
            pc_src_s = branch_taken_i ? PC_IMM : PC_PLUS4;
            retire_s = 1'b1;
          end
          default: begin
            // L, S, JAL, JALR: address / link add with immediate
            alu_src_s = 1'b1;
          end
        endcase
      end

`ifdef MULTICYCLE_CONTROL_MULDIV_EN
      ST_MULDIV_WAIT: aluop_s = ALUOP_RTYPE;
`endif

      ST_MEM: begin
        dmem_req_s  = 1'b1;
        mem_read_s  = (cls_q == CLS_L);
        mem_write_s = (cls_q == CLS_S);
        // Stores have nothing to write back, so they retire on the ack
        if ((cls_q == CLS_S) && dmem_ack_i) begin
          pc_we_s  = 1'b1;
          retire_s = 1'b1;
        end
      end

      ST_WB: begin
        reg_write_s = 1'b1;
        pc_we_s     = 1'b1;
        retire_s    = 1'b1;
        if (cls_q == CLS_L) begin
          memtoreg_s = WB_MEM;
        end else if (is_link(cls_q)) begin
          memtoreg_s = WB_PC4;
        end
        if (cls_q == CLS_JAL) begin
          pc_src_s = PC_IMM;
        end else if (cls_q == CLS_JALR) begin
          pc_src_s = PC_ALU;
        end
      end

      default: ;
    endcase
  end

  // Reset blanks every output so an abandoned instruction cannot commit
  assign run_s = !rst_i;

  assign imem_req_o     = run_s & imem_req_s;
  assign ir_we_o        = run_s & ir_we_s;
  assign dmem_req_o     = run_s & dmem_req_s;
  assign MemRead_o      = run_s & mem_read_s;
  assign MemWrite_o     = run_s & mem_write_s;
  assign RegWrite_o     = run_s & reg_write_s;
  assign MemtoReg_o     = run_s ? MEMTOREG_W'(memtoreg_s) : '0;
  assign ALUOp_o        = run_s ? ALUOP_W'(aluop_s) : '0;
  assign ALUSrc_o       = run_s & alu_src_s;
  assign alu_a_sel_o    = run_s & alu_a_sel_s;
  assign pc_we_o        = run_s & pc_we_s;
  assign pc_src_o       = run_s ? pc_src_s : 2'd0;
  assign muldiv_start_o = run_s & muldiv_start_s;
  assign retire_o       = run_s & retire_s;
  assign retire_cnt_o   = retire_cnt_q;
  assign trap_o         = run_s & (state_q == ST_TRAP);
  assign trap_cause_o   = run_s ? cause_q : TRAP_NONE;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard testbench for multicycle_control

module tb_multicycle_control;

  localparam int TMO = 4;
  localparam int CW  = 3;

  localparam logic [6:0] R_OP     = 7'b0110011;
  localparam logic [6:0] I_OP     = 7'b0010011;
  localparam logic [6:0] S_OP     = 7'b0100011;
  localparam logic [6:0] L_OP     = 7'b0000011;
  localparam logic [6:0] B_OP     = 7'b1100011;
  localparam logic [6:0] JAL_OP   = 7'b1101111;
  localparam logic [6:0] JALR_OP  = 7'b1100111;
  localparam logic [6:0] AUIPC_OP = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, branch_taken_i, imem_ack_i, dmem_ack_i, muldiv_done_i;
  logic [6:0]    opcode_i, funct7_i;
  logic          imem_req_o, ir_we_o, dmem_req_o, MemRead_o, MemWrite_o, RegWrite_o;
  logic [1:0]    MemtoReg_o, ALUOp_o, pc_src_o, trap_cause_o;
  logic          ALUSrc_o, alu_a_sel_o, pc_we_o, muldiv_start_o, retire_o, trap_o;
  logic [CW-1:0] retire_cnt_o;

  multicycle_control #(
    .ALUOP_W(2), .MEMTOREG_W(2), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .funct7_i(funct7_i),
    .branch_taken_i(branch_taken_i), .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
    .muldiv_done_i(muldiv_done_i), .imem_req_o(imem_req_o), .ir_we_o(ir_we_o),
    .dmem_req_o(dmem_req_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ALUOp_o(ALUOp_o),
    .ALUSrc_o(ALUSrc_o), .alu_a_sel_o(alu_a_sel_o), .pc_we_o(pc_we_o),
    .pc_src_o(pc_src_o), .muldiv_start_o(muldiv_start_o), .retire_o(retire_o),
    .retire_cnt_o(retire_cnt_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o)
  );

  typedef struct packed {
    logic          imem_req, ir_we, dmem_req, mem_read, mem_write, reg_write;
    logic [1:0]    mem_to_reg, alu_op;
    logic          alu_src, alu_a_sel, pc_we;
    logic [1:0]    pc_src;
    logic          muldiv_start, retire, trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] cnt;
  } outs_t;

  typedef struct packed {
    logic rst, imem_ack, dmem_ack, taken, mdone;
  } stim_t;

  outs_t   exp_q[$];
  string   tag_q[$];
  stim_t   stim_q[$];
  int      n_vec = 0;
  int      n_err = 0;
  logic [CW-1:0] exp_cnt;
  logic    idle_ack;
  outs_t   obs, expv;
  string   cur_tag;

  assign obs = {imem_req_o, ir_we_o, dmem_req_o, MemRead_o, MemWrite_o, RegWrite_o,
                MemtoReg_o, ALUOp_o, ALUSrc_o, alu_a_sel_o, pc_we_o, pc_src_o,
                muldiv_start_o, retire_o, trap_o, trap_cause_o, retire_cnt_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: one expected output vector per clock, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      expv    = exp_q.pop_front();
      cur_tag = tag_q.pop_front();
      check(cur_tag, 64'(obs), 64'(expv));
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s          = '0;
    s.imem_ack = idle_ack;
    s.dmem_ack = idle_ack;
    return s;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {R_OP, I_OP, S_OP, L_OP, B_OP, JAL_OP, JALR_OP, AUIPC_OP};
  endfunction

  task automatic push(input string tag, input stim_t s, input outs_t e);
    e.cnt = exp_cnt;
    if (e.retire) exp_cnt = exp_cnt + CW'(1);
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Drive queued stimulus, one entry per clock, starting just after a rising edge
  task automatic run();
    stim_t s;
    while (stim_q.size() != 0) begin
      s              = stim_q.pop_front();
      rst_i          = s.rst;
      imem_ack_i     = s.imem_ack;
      dmem_ack_i     = s.dmem_ack;
      branch_taken_i = s.taken;
      muldiv_done_i  = s.mdone;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add_reset(input int n);
    stim_t s;
    outs_t e;
    s     = '0;
    s.rst = 1'b1;
    e     = '0;
    for (int i = 0; i < n; i++) begin
      push("reset", s, e);
      exp_cnt = '0;
    end
  endtask

  // Trap is absorbing: acks and done held high must not wake anything up
  task automatic trap_tail(input string nm, input logic [1:0] cause);
    stim_t s;
    outs_t e;
    s = '1;
    s.rst = 1'b0;
    e = '0;
    e.trap = 1'b1;
    e.trap_cause = cause;
    for (int i = 0; i < 3; i++) push({nm, ":trap"}, s, e);
  endtask

  task automatic instr(input string nm, input logic [6:0] opc, input logic [6:0] f7,
                       input int iw, input int dw, input logic taken, input int mw,
                       input bit abort_wb);
    stim_t s;
    outs_t e;
    bit    md;
    opcode_i = opc;
    funct7_i = f7;
    md = 1'b0;
`ifdef MULTICYCLE_CONTROL_MULDIV_EN
    md = (opc == R_OP) && (f7 == 7'b0000001);
`endif
    for (int i = 0; i < iw && i < TMO; i++) begin
      s = idle(); s.imem_ack = 1'b0;
      e = '0; e.imem_req = 1'b1;
      push({nm, ":fetch_wait"}, s, e);
    end
    if (iw >= TMO) begin
      trap_tail(nm, 2'd2);
      run();
      return;
    end
    s = idle(); s.imem_ack = 1'b1;
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
    push({nm, ":fetch"}, s, e);
    s = idle(); e = '0;
    push({nm, ":decode"}, s, e);
    if (!legal(opc)) begin
      trap_tail(nm, 2'd1);
      run();
      return;
    end
    s = idle(); s.taken = taken; e = '0;
    case (opc)
      R_OP:     e.alu_op = 2'b10;
      I_OP:     begin e.alu_op = 2'b11; e.alu_src = 1'b1; end
      AUIPC_OP: begin e.alu_src = 1'b1; e.alu_a_sel = 1'b1; end
      B_OP:     begin
        e.alu_op = 2'b01; e.pc_we = 1'b1; e.retire = 1'b1;
        e.pc_src = taken ? 2'd1 : 2'd0;
      end
      default:  e.alu_src = 1'b1;
    endcase
    e.muldiv_start = md;
    push({nm, ":exec"}, s, e);
    if (opc == B_OP) begin
      run();
      return;
    end
    if (md) begin
      for (int i = 0; i < mw; i++) begin
        s = idle(); e = '0; e.alu_op = 2'b10;
        push({nm, ":muldiv_wait"}, s, e);
      end
      s = idle(); s.mdone = 1'b1; e = '0; e.alu_op = 2'b10;
      push({nm, ":muldiv_done"}, s, e);
    end
    if (opc == L_OP || opc == S_OP) begin
      for (int i = 0; i < dw && i < TMO; i++) begin
        s = idle(); s.dmem_ack = 1'b0;
        e = '0; e.dmem_req = 1'b1;
        e.mem_read = (opc == L_OP); e.mem_write = (opc == S_OP);
        push({nm, ":mem_wait"}, s, e);
      end
      if (dw >= TMO) begin
        trap_tail(nm, 2'd3);
        run();
        return;
      end
      s = idle(); s.dmem_ack = 1'b1;
      e = '0; e.dmem_req = 1'b1;
      e.mem_read = (opc == L_OP); e.mem_write = (opc == S_OP);
      if (opc == S_OP) begin e.pc_we = 1'b1; e.retire = 1'b1; end
      push({nm, ":mem_ack"}, s, e);
      if (opc == S_OP) begin
        run();
        return;
      end
    end
    s = idle(); e = '0;
    if (abort_wb) begin
      s.rst = 1'b1;
      push({nm, ":wb_abort"}, s, e);
      exp_cnt = '0;
      run();
      return;
    end
    e.reg_write = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
    if (opc == L_OP) e.mem_to_reg = 2'd1;
    else if (opc == JAL_OP || opc == JALR_OP) e.mem_to_reg = 2'd2;
    if (opc == JAL_OP) e.pc_src = 2'd1;
    else if (opc == JALR_OP) e.pc_src = 2'd2;
    push({nm, ":wb"}, s, e);
    run();
  endtask

  initial begin
    rst_i = 1'b1; imem_ack_i = 1'b0; dmem_ack_i = 1'b0; branch_taken_i = 1'b0;
    muldiv_done_i = 1'b0; opcode_i = 7'd0; funct7_i = 7'd0;
    exp_cnt = '0; idle_ack = 1'b0;
    @(posedge clk);
    #1;
    add_reset(1);
    run();

    idle_ack = 1'b1;
    instr("r_acks_high", R_OP, 7'd0, 0, 0, 1'b0, 0, 1'b0);
    idle_ack = 1'b0;
    instr("load_dw3",  L_OP,     7'd0, 0, 3, 1'b0, 0, 1'b0);
    instr("br_taken",  B_OP,     7'd0, 0, 0, 1'b1, 0, 1'b0);
    instr("br_not",    B_OP,     7'd0, 0, 0, 1'b0, 0, 1'b0);
    instr("itype",     I_OP,     7'd0, 0, 0, 1'b0, 0, 1'b0);
    instr("store",     S_OP,     7'd0, 0, 0, 1'b0, 0, 1'b0);
    instr("store_dw2", S_OP,     7'd0, 1, 2, 1'b0, 0, 1'b0);
    instr("auipc",     AUIPC_OP, 7'd0, 0, 0, 1'b0, 0, 1'b0);
    instr("jal",       JAL_OP,   7'd0, 0, 0, 1'b1, 0, 1'b0);
    instr("jalr",      JALR_OP,  7'd0, 0, 0, 1'b0, 0, 1'b0);
    instr("imem_ack_at_limit", R_OP, 7'd0, TMO - 1, 0, 1'b0, 0, 1'b0);
    instr("muldiv",    R_OP,     7'b0000001, 0, 0, 1'b0, 3, 1'b0);
    instr("reset_in_wb", I_OP,   7'd0, 0, 0, 1'b0, 0, 1'b1);
    instr("after_abort", R_OP,   7'd0, 0, 0, 1'b0, 0, 1'b0);

    instr("illegal",   7'b0000000, 7'd0, 0, 0, 1'b0, 0, 1'b0);
    add_reset(1);
    run();
    instr("after_illegal", R_OP, 7'd0, 0, 0, 1'b0, 0, 1'b0);

    instr("imem_timeout", R_OP, 7'd0, TMO, 0, 1'b0, 0, 1'b0);
    add_reset(1);
    run();
    instr("dmem_timeout", L_OP, 7'd0, 0, TMO, 1'b0, 0, 1'b0);
    add_reset(2);
    run();

    for (int i = 0; i < 10; i++) begin
      instr("br_wrap", B_OP, 7'd0, i % 2, 0, logic'(i % 2), 0, 1'b0);
    end
    instr("final_r", R_OP, 7'd0, 0, 0, 1'b0, 0, 1'b0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
